// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: serialises L1 I-cache refills and L1 D-cache refills or
// write-backs onto a single L2 request port. The completion pulse and the
// refill line go back to whichever side owns the current transaction.
module l1_l2_arbiter #(
  parameter int LINE_W = 512,
  parameter int ADDR_W = 26
) (
  input  logic              clk,
  input  logic              rst,
  // I-side
  input  logic              read_I_L2,
  input  logic [ADDR_W-1:0] addr_I_L2,
  output logic              ready_L2_I,
  output logic [LINE_W-1:0] rdata_L2_I,
  // D-side
  input  logic              read_D_L2,
  input  logic              write_D_L2,
  input  logic [17:0]       tag_D_L2,
  input  logic [7:0]        index_D_L2,
  input  logic [17:0]       write_tag_D_L2,
  input  logic [7:0]        write_index_D_L2,
  input  logic [LINE_W-1:0] wdata_D_L2,
  output logic              ready_L2_D,
  output logic [LINE_W-1:0] rdata_L2_D,
  // L2 side
  output logic              read_ARB_L2,
  output logic              write_ARB_L2,
  output logic [ADDR_W-1:0] addr_ARB_L2,
  output logic [LINE_W-1:0] wdata_ARB_L2,
  input  logic              ready_L2_ARB,
  input  logic [LINE_W-1:0] rdata_L2_ARB
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_t;

  state_t            state_q, state_d;
  side_t             owner_q, last_grant_q;
  logic              op_write_q;
  logic              mask_i_q, mask_d_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_i_q, rdata_d_q;

  logic              want_i, want_d;
  side_t             grant_side;
  logic              grant_write;
  logic [ADDR_W-1:0] grant_addr;
  logic [LINE_W-1:0] grant_wdata;

  // Next-state and grant selection: round-robin between the two sides, with
  // a D write-back taking precedence over a simultaneous D refill.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    want_i      = read_I_L2 & ~mask_i_q;
    want_d      = (read_D_L2 | write_D_L2) & ~mask_d_q;
    grant_side  = SIDE_I;
    grant_write = 1'b0;
    grant_addr  = addr_I_L2;
    grant_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (want_i || want_d) begin
          state_d = BUSY;
          if (want_d && (!want_i || last_grant_q == SIDE_I)) begin
            grant_side = SIDE_D;
            if (write_D_L2) begin
              grant_write = 1'b1;
              grant_addr  = {write_tag_D_L2, write_index_D_L2};
              grant_wdata = wdata_D_L2;
            end else begin
              grant_addr  = {tag_D_L2, index_D_L2};
            end
          end
        end
      end
      BUSY:    if (ready_L2_ARB) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus the latched transaction, masks and returned lines.
  always_ff @(posedge clk) begin
    // NOTE: all state here updates with non-blocking assignments so every
    // register sees the values from before this clock edge.
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= SIDE_I;
      last_grant_q <= SIDE_D;
      op_write_q   <= 1'b0;
      mask_i_q     <= 1'b0;
      mask_d_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_i_q    <= '0;
      rdata_d_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          // The masks only cover the single IDLE cycle after a completion.
          mask_i_q <= 1'b0;
          mask_d_q <= 1'b0;
          if (state_d == BUSY) begin
            owner_q    <= grant_side;
            op_write_q <= grant_write;
            addr_q     <= grant_addr;
            wdata_q    <= grant_wdata;
          end
        end
        BUSY: begin
          if (ready_L2_ARB && !op_write_q) begin
            if (owner_q == SIDE_D) rdata_d_q <= rdata_L2_ARB;
            else                   rdata_i_q <= rdata_L2_ARB;
          end
        end
        RESP: begin
          // The L1 request is registered and stays high one cycle past ready.
          last_grant_q <= owner_q;
          mask_i_q     <= (owner_q == SIDE_I);
          mask_d_q     <= (owner_q == SIDE_D);
        end
        default: ;
      endcase
    end
  end

  assign read_ARB_L2  = (state_q == BUSY) && !op_write_q;
  assign write_ARB_L2 = (state_q == BUSY) &&  op_write_q;
  assign addr_ARB_L2  = addr_q;
  assign wdata_ARB_L2 = wdata_q;
  assign ready_L2_I   = (state_q == RESP) && (owner_q == SIDE_I);
  assign ready_L2_D   = (state_q == RESP) && (owner_q == SIDE_D);
  assign rdata_L2_I   = rdata_i_q;
  assign rdata_L2_D   = rdata_d_q;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Bench for l1_l2_arbiter: directed L1/L2 stimulus, a transaction-level
// model compared on every falling edge, and literal expectations per scenario.
module tb_l1_l2_arbiter;

  localparam int LINE_W = 512;
  localparam int ADDR_W = 26;

  logic              clk;
  logic              rst;
  logic              read_I_L2;
  logic [ADDR_W-1:0] addr_I_L2;
  logic              ready_L2_I;
  logic [LINE_W-1:0] rdata_L2_I;
  logic              read_D_L2, write_D_L2;
  logic [17:0]       tag_D_L2, write_tag_D_L2;
  logic [7:0]        index_D_L2, write_index_D_L2;
  logic [LINE_W-1:0] wdata_D_L2;
  logic              ready_L2_D;
  logic [LINE_W-1:0] rdata_L2_D;
  logic              read_ARB_L2, write_ARB_L2;
  logic [ADDR_W-1:0] addr_ARB_L2;
  logic [LINE_W-1:0] wdata_ARB_L2;
  logic              ready_L2_ARB;
  logic [LINE_W-1:0] rdata_L2_ARB;

  l1_l2_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .read_I_L2        (read_I_L2),
    .addr_I_L2        (addr_I_L2),
    .ready_L2_I       (ready_L2_I),
    .rdata_L2_I       (rdata_L2_I),
    .read_D_L2        (read_D_L2),
    .write_D_L2       (write_D_L2),
    .tag_D_L2         (tag_D_L2),
    .index_D_L2       (index_D_L2),
    .write_tag_D_L2   (write_tag_D_L2),
    .write_index_D_L2 (write_index_D_L2),
    .wdata_D_L2       (wdata_D_L2),
    .ready_L2_D       (ready_L2_D),
    .rdata_L2_D       (rdata_L2_D),
    .read_ARB_L2      (read_ARB_L2),
    .write_ARB_L2     (write_ARB_L2),
    .addr_ARB_L2      (addr_ARB_L2),
    .wdata_ARB_L2     (wdata_ARB_L2),
    .ready_L2_ARB     (ready_L2_ARB),
    .rdata_L2_ARB     (rdata_L2_ARB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rdy_i  = 0;
  int n_rdy_d  = 0;
  bit cmp_en   = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic              d_side;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } txn_t;

  txn_t              m_txn     = '0;
  bit                m_at_l2   = 0;  // transaction outstanding at L2
  bit                m_pulse   = 0;  // completion pulse visible this cycle
  bit                m_last_d  = 1;  // last completed owner was D
  bit                m_stale_i = 0;  // side's request is a hold-over this cycle
  bit                m_stale_d = 0;
  logic [LINE_W-1:0] m_line_i  = '0;
  logic [LINE_W-1:0] m_line_d  = '0;

  task automatic model_step();
    bit want_i, want_d, pick_d;
    if (rst) begin
      m_txn = '0; m_at_l2 = 0; m_pulse = 0; m_last_d = 1;
      m_stale_i = 0; m_stale_d = 0; m_line_i = '0; m_line_d = '0;
    end else if (m_pulse) begin
      m_pulse  = 0;
      m_last_d = m_txn.d_side;
      if (m_txn.d_side) m_stale_d = 1; else m_stale_i = 1;
    end else if (m_at_l2) begin
      if (ready_L2_ARB) begin
        m_at_l2 = 0;
        m_pulse = 1;
        if (!m_txn.wr) begin
          if (m_txn.d_side) m_line_d = rdata_L2_ARB; else m_line_i = rdata_L2_ARB;
        end
      end
    end else begin
      want_i = read_I_L2 && !m_stale_i;
      want_d = (read_D_L2 || write_D_L2) && !m_stale_d;
      m_stale_i = 0;
      m_stale_d = 0;
      if (want_i || want_d) begin
        pick_d = want_i ? (want_d && !m_last_d) : 1'b1;
        m_at_l2 = 1;
        if (!pick_d)
          m_txn = '{d_side: 1'b0, wr: 1'b0, addr: addr_I_L2, wdata: '0};
        else if (write_D_L2)
          m_txn = '{d_side: 1'b1, wr: 1'b1, addr: {write_tag_D_L2, write_index_D_L2},
                    wdata: wdata_D_L2};
        else
          m_txn = '{d_side: 1'b1, wr: 1'b0, addr: {tag_D_L2, index_D_L2}, wdata: '0};
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every falling edge once reset has been applied.
  initial forever begin
    @(negedge clk);
    if (ready_L2_I === 1'b1) n_rdy_i++;
    if (ready_L2_D === 1'b1) n_rdy_d++;
    if (cmp_en) begin
      check("read_ARB_L2",  read_ARB_L2,  m_at_l2 && !m_txn.wr);
      check("write_ARB_L2", write_ARB_L2, m_at_l2 &&  m_txn.wr);
      check("ready_L2_I",   ready_L2_I,   m_pulse && !m_txn.d_side);
      check("ready_L2_D",   ready_L2_D,   m_pulse &&  m_txn.d_side);
      check("rdata_L2_I",   rdata_L2_I,   m_line_i);
      check("rdata_L2_D",   rdata_L2_D,   m_line_d);
      if (m_at_l2) begin
        check("addr_ARB_L2",  addr_ARB_L2,  m_txn.addr);
        check("wdata_ARB_L2", wdata_ARB_L2, m_txn.wdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_l2_req();
    bit seen;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (read_ARB_L2 || write_ARB_L2) begin
        seen = 1;
        break;
      end
      cyc();
    end
    check("l2_req_seen", seen, 1'b1);
  endtask

  // Acting as L2: ready arrives in the lat-th BUSY cycle; returns in RESP.
  task automatic complete_l2(input int lat, input logic [LINE_W-1:0] line);
    repeat (lat - 1) cyc();
    ready_L2_ARB = 1'b1;
    rdata_L2_ARB = line;
    cyc();
    ready_L2_ARB = 1'b0;
    rdata_L2_ARB = ~line;
  endtask

  // Registered L1 request stays high through the IDLE cycle after ready.
  task automatic drop_after_holdover(input bit side_d);
    cyc();
    cyc();
    if (side_d) begin read_D_L2 = 1'b0; write_D_L2 = 1'b0; end
    else        read_I_L2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [LINE_W-1:0] ALL5 = {128{4'h5}};
  localparam logic [LINE_W-1:0] ALLA = {128{4'hA}};
  localparam logic [LINE_W-1:0] LN_X = {16{32'h0BAD_F00D}};
  localparam logic [LINE_W-1:0] LN_R = {16{32'h1234_5678}};
  localparam logic [LINE_W-1:0] LN_I = {16{32'hCAFE_0001}};
  localparam logic [LINE_W-1:0] LN_D = {16{32'hCAFE_0002}};

  int base_i, base_d;

  initial begin
    rst = 1'b1;
    read_I_L2 = 0; addr_I_L2 = '0;
    read_D_L2 = 0; write_D_L2 = 0;
    tag_D_L2 = '0; index_D_L2 = '0;
    write_tag_D_L2 = '0; write_index_D_L2 = '0; wdata_D_L2 = '0;
    ready_L2_ARB = 0; rdata_L2_ARB = '0;
    cyc();
    cyc();
    check("rst_read_ARB",  read_ARB_L2,  1'b0);
    check("rst_write_ARB", write_ARB_L2, 1'b0);
    check("rst_addr",      addr_ARB_L2,  '0);
    check("rst_wdata",     wdata_ARB_L2, '0);
    check("rst_ready_I",   ready_L2_I,   1'b0);
    check("rst_ready_D",   ready_L2_D,   1'b0);
    check("rst_rdata_I",   rdata_L2_I,   '0);
    check("rst_rdata_D",   rdata_L2_D,   '0);
    check("model_last_is_D", m_last_d,   1'b1);
    rst = 1'b0;
    cmp_en = 1;

    // D refill only, L2 ready in the 4th BUSY cycle
    tag_D_L2 = 18'h1ABCD; index_D_L2 = 8'h3F; read_D_L2 = 1'b1;
    wait_l2_req();
    check("d_rd_read",       read_ARB_L2,  1'b1);
    check("d_rd_write",      write_ARB_L2, 1'b0);
    check("d_rd_addr",       addr_ARB_L2,  26'h1ABCD3F);
    check("model_d_rd_addr", m_txn.addr,   26'h1ABCD3F);
    complete_l2(4, ALL5);
    check("d_rd_ready",      ready_L2_D,   1'b1);
    check("d_rd_rdata",      rdata_L2_D,   ALL5);
    check("model_d_rd_line", m_line_d,     ALL5);
    // stale hold-over must not issue a second read
    drop_after_holdover(1'b1);
    check("stale_no_req",    read_ARB_L2,  1'b0);
    cyc();
    // genuine new request is granted
    tag_D_L2 = 18'h00001; index_D_L2 = 8'h02; read_D_L2 = 1'b1;
    wait_l2_req();
    check("d_rd2_addr",      addr_ARB_L2,  26'h0000102);
    complete_l2(1, LN_X);
    check("d_rd2_rdata",     rdata_L2_D,   LN_X);
    drop_after_holdover(1'b1);

    // D write-back, ready after 2 cycles; refill tag/index are decoys
    tag_D_L2 = 18'h3FFFF; index_D_L2 = 8'hFF;
    write_tag_D_L2 = 18'h00012; write_index_D_L2 = 8'h01; wdata_D_L2 = ALLA;
    write_D_L2 = 1'b1;
    wait_l2_req();
    check("d_wb_write",      write_ARB_L2, 1'b1);
    check("d_wb_read",       read_ARB_L2,  1'b0);
    check("d_wb_addr",       addr_ARB_L2,  26'h0001201);
    check("d_wb_wdata",      wdata_ARB_L2, ALLA);
    base_d = n_rdy_d;
    complete_l2(2, {128{4'h3}});
    check("d_wb_ready",      ready_L2_D,   1'b1);
    check("d_wb_rdata_kept", rdata_L2_D,   LN_X);
    drop_after_holdover(1'b1);
    check("d_wb_one_pulse",  n_rdy_d - base_d, 1);

    // D write-back and refill together: write first, refill later
    write_tag_D_L2 = 18'h2AAAA; write_index_D_L2 = 8'h55;
    wdata_D_L2 = {16{32'hDEADBEEF}};
    tag_D_L2 = 18'h15555; index_D_L2 = 8'hAA;
    write_D_L2 = 1'b1; read_D_L2 = 1'b1;
    wait_l2_req();
    check("d_both_wr_first", write_ARB_L2, 1'b1);
    check("d_both_wr_addr",  addr_ARB_L2,  26'h2AAAA55);
    complete_l2(1, LN_X);
    cyc();
    cyc();
    write_D_L2 = 1'b0;
    wait_l2_req();
    check("d_both_rd_next",  read_ARB_L2,  1'b1);
    check("d_both_rd_addr",  addr_ARB_L2,  26'h15555AA);
    check("d_both_rd_wdata", wdata_ARB_L2, '0);
    complete_l2(2, LN_R);
    check("d_both_rdata",    rdata_L2_D,   LN_R);
    drop_after_holdover(1'b1);

    // Simultaneous I and D refills after reset: I, D, then I again
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst2_rdata_D",    rdata_L2_D,   '0);
    base_i = n_rdy_i; base_d = n_rdy_d;
    addr_I_L2 = 26'h2000001; read_I_L2 = 1'b1;
    tag_D_L2 = 18'h00ABC; index_D_L2 = 8'h12; read_D_L2 = 1'b1;
    wait_l2_req();
    check("tie1_i_first",    addr_ARB_L2,  26'h2000001);
    complete_l2(1, LN_I);
    check("tie1_ready_I",    ready_L2_I,   1'b1);
    check("tie1_no_ready_D", ready_L2_D,   1'b0);
    drop_after_holdover(1'b0);
    wait_l2_req();
    check("tie1_d_second",   addr_ARB_L2,  26'h00ABC12);
    complete_l2(3, LN_D);
    check("tie1_rdata_D",    rdata_L2_D,   LN_D);
    check("tie1_rdata_I",    rdata_L2_I,   LN_I);
    drop_after_holdover(1'b1);
    addr_I_L2 = 26'h3FFFFFF; read_I_L2 = 1'b1;
    tag_D_L2 = 18'h3FFFF; index_D_L2 = 8'h00; read_D_L2 = 1'b1;
    wait_l2_req();
    check("tie2_i_again",    addr_ARB_L2,  26'h3FFFFFF);
    complete_l2(2, ALL5);
    drop_after_holdover(1'b0);
    wait_l2_req();
    check("tie2_d_after",    addr_ARB_L2,  26'h3FFFF00);
    complete_l2(1, ALLA);
    drop_after_holdover(1'b1);
    check("tie_pulses_I",    n_rdy_i - base_i, 2);
    check("tie_pulses_D",    n_rdy_d - base_d, 2);

    // Reset during BUSY, then a late L2 ready
    addr_I_L2 = 26'h0123456; read_I_L2 = 1'b1;
    wait_l2_req();
    cyc();
    rst = 1'b1;
    cyc();
    check("midrst_read",     read_ARB_L2,  1'b0);
    check("midrst_addr",     addr_ARB_L2,  '0);
    check("midrst_rdata_I",  rdata_L2_I,   '0);
    rst = 1'b0; read_I_L2 = 1'b0; read_D_L2 = 1'b0;
    base_i = n_rdy_i; base_d = n_rdy_d;
    cyc();
    complete_l2(1, {LINE_W{1'b1}});
    cyc();
    check("late_no_ready_I", n_rdy_i - base_i, 0);
    check("late_no_ready_D", n_rdy_d - base_d, 0);
    check("late_rdata_I",    rdata_L2_I,   '0);

    // Stray L2 ready while IDLE
    complete_l2(1, LN_R);
    cyc();
    check("stray_no_req",    read_ARB_L2 | write_ARB_L2, 1'b0);
    check("stray_no_ready",  n_rdy_i + n_rdy_d - base_i - base_d, 0);

    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
- Single-port arbiter between the L1 caches and the L2 cache.
- Accepts line-refill reads from the L1 instruction-cache controller, and line-refill reads or dirty-line write-backs from the L1 data-cache controller.
- Serialises these requests onto one L2 request port and returns the L2 completion (ready pulse plus refill line) to the requester that owns the transaction.
- Sits directly downstream of the L1 D/I controllers, directly upstream of the L2 controller.

Parameters:
- LINE_W, 512, cache line width in bits (data moved per transaction)
- ADDR_W, 26, line address width = 18-bit tag concatenated with 8-bit index

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- read_I_L2  in  1  I-side refill request (level, held until ready_L2_I)
- addr_I_L2  in  ADDR_W  I-side line address
- ready_L2_I  out  1  one-cycle completion pulse to I-side
- rdata_L2_I  out  LINE_W  refill line to I-side
- read_D_L2  in  1  D-side refill request (level)
- write_D_L2  in  1  D-side write-back request (level)
- tag_D_L2  in  18  D-side refill tag
- index_D_L2  in  8  D-side refill index
- write_tag_D_L2  in  18  D-side write-back tag
- write_index_D_L2  in  8  D-side write-back index
- wdata_D_L2  in  LINE_W  D-side victim line
- ready_L2_D  out  1  one-cycle completion pulse to D-side
- rdata_L2_D  out  LINE_W  refill line to D-side
- read_ARB_L2  out  1  L2 read request (level)
- write_ARB_L2  out  1  L2 write request (level)
- addr_ARB_L2  out  ADDR_W  L2 line address
- wdata_ARB_L2  out  LINE_W  L2 write line
- ready_L2_ARB  in  1  L2 completion pulse
- rdata_L2_ARB  in  LINE_W  L2 read line, valid with ready_L2_ARB

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.

States:
- IDLE: pick a requester.
- BUSY: L2 request outstanding.
- RESP: completion pulse cycle.

Reset:
- state=IDLE, owner=I, last_grant=D (so I wins the first tie), masks=0.
- All outputs 0: read/write_ARB_L2, addr, wdata, ready_L2_I/D, rdata_L2_I/D.
- Reset mid-BUSY drops the L2 request in the next cycle. Any subsequent ready_L2_ARB is ignored.

IDLE:
- Effective request per side = raw request AND NOT mask_side.
- D-side request = read_D_L2 OR write_D_L2. If both are asserted, the write-back is served first; read_D_L2 is then served in a later grant.
- Both sides requesting: grant the side that is not last_grant (round-robin). Single requester: grant it.
- On grant, latch owner, op, address and wdata into registers; next state BUSY.
- Address selection:
  - D write uses {write_tag_D_L2, write_index_D_L2}.
  - D read uses {tag_D_L2, index_D_L2}.
  - I read uses addr_I_L2.
- wdata_ARB_L2 = 0 for reads.

BUSY:
- read_ARB_L2 / write_ARB_L2 held high with stable addr/wdata.
- Latency: request sampled at cycle 0 → L2 request visible at cycle 1.
- On ready_L2_ARB: latch rdata (read ops only), deassert the L2 request next cycle, next state RESP.

RESP (exactly one cycle):
- ready_L2_<owner>=1.
- rdata_L2_<owner> = latched line; held until the next read completion to that side.
- Update last_grant=owner.
- Set mask_<owner>=1 for the following IDLE cycle only. This covers the registered request of the L1 controllers, which stays high one cycle after its ready.
- Next state IDLE.

General rules:
- ready_L2_ARB outside BUSY is ignored.
- A requester that drops its request in BUSY does not cancel the transaction; it completes normally.
- Total latency, request to ready_L2_X, is L2 latency + 3 cycles (IDLE sample, BUSY issue, RESP).

Test Plan:
- Reset then D read only:
  - Stimulus: tag_D_L2=18'h1ABCD, index_D_L2=8'h3F, L2 returns ready at BUSY cycle 4 with rdata=all-5s.
  - Response: read_ARB_L2=1, addr_ARB_L2=26'h1ABCD3F; ready_L2_D pulses one cycle later with rdata_L2_D=all-5s; write_ARB_L2 stays 0.
- D write-back:
  - Stimulus: write_tag=18'h00012, write_index=8'h01, wdata=all-A; ready after 2 cycles.
  - Response: write_ARB_L2=1, addr=26'h0001201, wdata_ARB_L2=all-A, single ready_L2_D pulse; rdata_L2_D unchanged.
- Simultaneous I and D read after reset:
  - Required order: I granted first, then D; then a new simultaneous pair grants I again (alternation).
  - Exactly one ready pulse per request.
- Stale request hold-over:
  - Stimulus: D keeps read_D_L2 high one cycle after ready_L2_D.
  - Response: no second L2 read is issued (mask).
  - Follow-up: a genuine new request two cycles later is granted.
- Reset mid-operation:
  - Stimulus: rst asserted during BUSY.
  - Response: next cycle all outputs 0 and state IDLE; a late ready_L2_ARB produces no ready_L2_I/D.
- Stray L2 ready:
  - Stimulus: ready_L2_ARB pulsed while in IDLE.
  - Response: no state change, no ready outputs.
